// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a host (master) and the register-bank peripheral (slave).
interface spi_reg_bank_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
  modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 read/write bank of NUM_REGS x DATA_W registers, all SPI pins oversampled on clk.
// Optional SPI_ERR_CNT_EN adds err_count_o, a saturating count of wrong-length frames.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out_o,
  output logic [NUM_REGS-1:0]        wr_stb_o,
  output logic                       busy_o
`ifdef SPI_ERR_CNT_EN
  ,
  output logic [7:0]                 err_count_o
`endif
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [2:0] ncs_sync_q, sclk_sync_q;
  logic [1:0] copi_sync_q;
  logic       ncs_rise, ncs_fall, sclk_rise, sclk_fall, ncs_s2, copi_s2;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   rx_q, rx_d, rx_shift;
  logic [DATA_W-1:0]    tx_q, tx_d, rd_data;
  logic                 rd_q, rd_d;
  logic                 cipo_q, cipo_d;
  logic                 active_q, active_d;
  logic [NUM_REGS-1:0]  wr_stb_q, wr_stb_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [ADDR_W-1:0]    frame_addr, cmd_addr;
`ifdef SPI_ERR_CNT_EN
  logic [7:0]           err_q, err_d;
`endif

  assign ncs_s2    = ncs_sync_q[1];
  assign copi_s2   = copi_sync_q[1];
  assign ncs_rise  =  ncs_sync_q[1]  & ~ncs_sync_q[2];
  assign ncs_fall  = ~ncs_sync_q[1]  &  ncs_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

  assign rx_shift   = {rx_q[FRAME_W-2:0], copi_s2};
  assign cmd_addr   = rx_shift[ADDR_W-1:0];
  assign frame_addr = rx_q[FRAME_W-2 -: ADDR_W];

  // Readback mux; addresses past NUM_REGS fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (cmd_addr == ADDR_W'(i)) rd_data = regs_q[i];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    rd_d     = rd_q;
    cipo_d   = cipo_q;
    active_d = active_q;
    wr_stb_d = '0;
    regs_d   = regs_q;
`ifdef SPI_ERR_CNT_EN
    err_d    = err_q;
`endif
    if (ncs_fall) begin
      state_d  = CMD;
      cnt_d    = '0;
      rx_d     = '0;
      tx_d     = '0;
      rd_d     = 1'b0;
      cipo_d   = 1'b0;
      active_d = 1'b1;
    end else if (ncs_rise && state_q != IDLE) begin
      state_d  = IDLE;
      active_d = 1'b0;
      cipo_d   = 1'b0;
      if (cnt_q == CNT_FRAME && rx_q[FRAME_W-1]) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (frame_addr == ADDR_W'(i)) begin
            regs_d[i]   = rx_q[DATA_W-1:0];
            wr_stb_d[i] = 1'b1;
          end
        end
      end
`ifdef SPI_ERR_CNT_EN
      if (cnt_q != CNT_FRAME && err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
    end else if (!ncs_s2) begin
      case (state_q)
        CMD: begin
          if (sclk_rise) begin
            rx_d  = rx_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_CMD) begin
              state_d = DATA;
              rd_d    = ~rx_shift[ADDR_W];
              tx_d    = rx_shift[ADDR_W] ? '0 : rd_data;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d = rx_shift;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          end else if (sclk_fall && rd_q) begin
            cipo_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync_q  <= '0;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      cipo_q      <= 1'b0;
      active_q    <= 1'b0;
      wr_stb_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef SPI_ERR_CNT_EN
      err_q       <= '0;
`endif
    end else begin
      ncs_sync_q  <= {ncs_sync_q[1:0], spi.ncs};
      sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
      copi_sync_q <= {copi_sync_q[0], spi.copi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      cipo_q      <= cipo_d;
      active_q    <= active_d;
      wr_stb_q    <= wr_stb_d;
      regs_q      <= regs_d;
`ifdef SPI_ERR_CNT_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    regs_out_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_out_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign wr_stb_o    = wr_stb_q;
  assign busy_o      = active_q;
  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = active_q;
`ifdef SPI_ERR_CNT_EN
  assign err_count_o = err_q;
`endif

endmodule
